// File: rtl/clk_presc_pkg.sv
// Shared types and helpers for the multi-channel clock prescaller.
// Optional feature macro: CLK_PRESC_SYNC_RESTART_EN (adds sync_restart).
`ifndef CLK_PRESC_PKG_MACROS
`define CLK_PRESC_PKG_MACROS
`define PRESC_DIV_T(W) logic [(W)-1:0]
`define PRESC_CH_ST_T(W) struct packed { \
   logic [(W)-1:0] div_shadow; \
   logic [(W)-1:0] div_active; \
   logic [(W)-1:0] cnt; \
   logic tick; \
   logic pclk; \
   logic pend; \
}
`endif

package clk_presc_pkg;

   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   localparam int DIV_W_DEF = 8;

   typedef `PRESC_DIV_T(DIV_W_DEF) presc_div_t;
   typedef `PRESC_CH_ST_T(DIV_W_DEF) presc_ch_st_t;

endpackage

// File: rtl/clk_presc_channel.sv
// One prescaller channel: shadowed divisor, wrap counter, tick and toggle.
// Optional feature macro: CLK_PRESC_SYNC_RESTART_EN (adds restart input).
module clk_presc_channel
   import clk_presc_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             we,
   input  logic [DIV_W-1:0] wdiv,
`ifdef CLK_PRESC_SYNC_RESTART_EN
   input  logic             restart,
`endif
   output logic             tick,
   output logic             pclk,
   output logic             pend
);

   typedef `PRESC_DIV_T(DIV_W) ch_div_t;
   typedef `PRESC_CH_ST_T(DIV_W) ch_st_t;

   localparam ch_div_t DIV_RST_V = ch_div_t'(DIV_RST);

   ch_st_t st_q;
   ch_st_t st_d;
   logic   clear;

`ifdef CLK_PRESC_SYNC_RESTART_EN
   assign clear = restart || !en;
`else
   assign clear = !en;
`endif

   always_comb begin
      st_d      = st_q;
      st_d.tick = 1'b0;
      if (clear) begin
         // Restart/disable: idle at 0; a same-edge write lands only in the shadow
         st_d.cnt        = '0;
         st_d.pclk       = 1'b0;
         st_d.div_active = st_q.div_shadow;
         st_d.pend       = 1'b0;
         if (we) begin
            st_d.div_shadow = wdiv;
         end
      end else begin
         if (st_q.cnt == st_q.div_active) begin
            st_d.cnt        = '0;
            st_d.tick       = 1'b1;
            st_d.pclk       = ~st_q.pclk;
            st_d.div_active = st_q.div_shadow;
            st_d.pend       = 1'b0;
         end else begin
            st_d.cnt = st_q.cnt + 1'b1;
         end
         // A write on the wrap edge keeps pend set for the following period
         if (we) begin
            st_d.div_shadow = wdiv;
            st_d.pend       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q.div_shadow <= DIV_RST_V;
         st_q.div_active <= DIV_RST_V;
         st_q.cnt        <= '0;
         st_q.tick       <= 1'b0;
         st_q.pclk       <= 1'b0;
         st_q.pend       <= 1'b0;
      end else begin
         st_q <= st_d;
      end
   end

   assign tick = st_q.tick;
   assign pclk = st_q.pclk;
   assign pend = st_q.pend;

endmodule

// File: rtl/clk_prescaller_v2.sv
// Multi-channel programmable synchronous prescaller (ticks + 50% levels).
// Optional feature macro: CLK_PRESC_SYNC_RESTART_EN (adds sync_restart).
module clk_prescaller_v2
   import clk_presc_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 0,
   localparam int CH_W   = ch_idx_w(NUM_CH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_PRESC_SYNC_RESTART_EN
   input  logic              sync_restart,
`endif
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] pclk_out,
   output logic [NUM_CH-1:0] cfg_pending
);

   logic [NUM_CH-1:0] ch_we;

   // Out-of-range channel numbers match no strobe and are dropped
   always_comb begin
      ch_we = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_presc_channel #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .clk     (sys_clk),
         .rst     (sys_rst),
         .en      (ch_en[g]),
         .we      (ch_we[g]),
         .wdiv    (cfg_div),
`ifdef CLK_PRESC_SYNC_RESTART_EN
         .restart (sync_restart),
`endif
         .tick    (tick_out[g]),
         .pclk    (pclk_out[g]),
         .pend    (cfg_pending[g])
      );
   end

endmodule
